// File: rtl/ftq.sv
// Fetch target queue between the BPU and the IFU.
// Three-pointer circular buffer: BPU writes, IFU sends, backend commits.
module ftq #(
  parameter int FRONTEND_FTQ_SIZE = 8,
  parameter int COMMIT_WIDTH      = 2,
  parameter int ADDR_WIDTH        = 32,
  localparam int IDW  = $clog2(FRONTEND_FTQ_SIZE),
  localparam int CNTW = IDW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bpu_valid_i,
  input  logic [ADDR_WIDTH-1:0]   bpu_start_pc_i,
  input  logic [2:0]              bpu_length_i,
  output logic                    bpu_ready_o,
  output logic                    ifu_valid_o,
  output logic [ADDR_WIDTH-1:0]   ifu_start_pc_o,
  output logic [2:0]              ifu_length_o,
  output logic [IDW-1:0]          ifu_ftq_id_o,
  input  logic                    ifu_ready_i,
  input  logic [COMMIT_WIDTH-1:0] backend_commit_block_i,
  input  logic                    backend_flush_i,
  input  logic [IDW-1:0]          backend_flush_ftq_id_i,
  output logic [CNTW-1:0]         count_o,
  output logic                    error_o
);

  localparam logic [CNTW-1:0] FULL = CNTW'(FRONTEND_FTQ_SIZE);

  logic [ADDR_WIDTH-1:0] pc_mem  [FRONTEND_FTQ_SIZE];
  logic [2:0]            len_mem [FRONTEND_FTQ_SIZE];

  logic [IDW-1:0]  bpu_ptr_q, bpu_ptr_d;
  logic [IDW-1:0]  ifu_ptr_q, ifu_ptr_d;
  logic [IDW-1:0]  comm_ptr_q, comm_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] sent_q, sent_d;
  logic            error_q, error_d;

  logic            push;
  logic            send;
  logic [CNTW-1:0] k;
  logic [CNTW-1:0] commit_n;
  logic            over;
  logic [IDW-1:0]  flush_id_exp;

  assign bpu_ready_o    = (count_q != FULL);
  assign ifu_valid_o    = (sent_q < count_q) & ~backend_flush_i;
  assign ifu_start_pc_o = pc_mem[ifu_ptr_q];
  assign ifu_length_o   = len_mem[ifu_ptr_q];
  assign ifu_ftq_id_o   = ifu_ptr_q;
  assign count_o        = count_q;
  assign error_o        = error_q;

  assign push = bpu_valid_i & bpu_ready_o & ~backend_flush_i;
  assign send = ifu_valid_o & ifu_ready_i;

  always_comb begin
    k = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      k = k + {{(CNTW-1){1'b0}}, backend_commit_block_i[i]};
    end
  end

  // Only already-sent blocks may retire; any excess is a backend bug.
  assign over     = (k > sent_q);
  assign commit_n = over ? sent_q : k;

  always_comb begin
    comm_ptr_d   = comm_ptr_q + commit_n[IDW-1:0];
    bpu_ptr_d    = bpu_ptr_q + IDW'(push);
    ifu_ptr_d    = ifu_ptr_q + IDW'(send);
    count_d      = count_q + CNTW'(push) - commit_n;
    sent_d       = sent_q + CNTW'(send) - commit_n;
    flush_id_exp = comm_ptr_d - IDW'(1);
    error_d      = error_q | over;
    if (backend_flush_i) begin
      bpu_ptr_d = comm_ptr_d;
      ifu_ptr_d = comm_ptr_d;
      count_d   = '0;
      sent_d    = '0;
      if (backend_flush_ftq_id_i != flush_id_exp) begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpu_ptr_q  <= '0;
      ifu_ptr_q  <= '0;
      comm_ptr_q <= '0;
      count_q    <= '0;
      sent_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      bpu_ptr_q  <= bpu_ptr_d;
      ifu_ptr_q  <= ifu_ptr_d;
      comm_ptr_q <= comm_ptr_d;
      count_q    <= count_d;
      sent_q     <= sent_d;
      error_q    <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[bpu_ptr_q]  <= bpu_start_pc_i;
      len_mem[bpu_ptr_q] <= bpu_length_i;
    end
  end

endmodule

// File: tb/tb_ftq.sv
// Directed bench for ftq.
// Hand-computed expectations, one check task.
module tb_ftq;

  logic        clk;
  logic        rst_n;
  logic        bpu_valid_i;
  logic [31:0] bpu_start_pc_i;
  logic [2:0]  bpu_length_i;
  logic        bpu_ready_o;
  logic        ifu_valid_o;
  logic [31:0] ifu_start_pc_o;
  logic [2:0]  ifu_length_o;
  logic [2:0]  ifu_ftq_id_o;
  logic        ifu_ready_i;
  logic [1:0]  backend_commit_block_i;
  logic        backend_flush_i;
  logic [2:0]  backend_flush_ftq_id_i;
  logic [3:0]  count_o;
  logic        error_o;

  int n_run;
  int n_fail;

  ftq dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .bpu_valid_i            (bpu_valid_i),
    .bpu_start_pc_i         (bpu_start_pc_i),
    .bpu_length_i           (bpu_length_i),
    .bpu_ready_o            (bpu_ready_o),
    .ifu_valid_o            (ifu_valid_o),
    .ifu_start_pc_o         (ifu_start_pc_o),
    .ifu_length_o           (ifu_length_o),
    .ifu_ftq_id_o           (ifu_ftq_id_o),
    .ifu_ready_i            (ifu_ready_i),
    .backend_commit_block_i (backend_commit_block_i),
    .backend_flush_i        (backend_flush_i),
    .backend_flush_ftq_id_i (backend_flush_ftq_id_i),
    .count_o                (count_o),
    .error_o                (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic push(input logic [31:0] pc, input logic [2:0] len);
    bpu_valid_i    = 1'b1;
    bpu_start_pc_i = pc;
    bpu_length_i   = len;
    cyc();
    bpu_valid_i = 1'b0;
  endtask

  task automatic send_n(input int n);
    ifu_ready_i = 1'b1;
    repeat (n) cyc();
    ifu_ready_i = 1'b0;
  endtask

  task automatic commit(input logic [1:0] v);
    backend_commit_block_i = v;
    cyc();
    backend_commit_block_i = 2'b00;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n                  = 1'b0;
    bpu_valid_i            = 1'b0;
    bpu_start_pc_i         = '0;
    bpu_length_i           = '0;
    ifu_ready_i            = 1'b0;
    backend_commit_block_i = 2'b00;
    backend_flush_i        = 1'b0;
    backend_flush_ftq_id_i = '0;

    #3;
    chk("rst_count", count_o, 0);
    chk("rst_ready", bpu_ready_o, 1);
    chk("rst_ifu_valid", ifu_valid_o, 0);
    chk("rst_error", error_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // three pushes, IFU stalled
    bpu_valid_i    = 1'b1;
    bpu_start_pc_i = 32'h1c00_0000;
    bpu_length_i   = 3'd4;
    #1;
    chk("no_bypass", ifu_valid_o, 0);
    cyc();
    bpu_valid_i = 1'b0;
    push(32'h1c00_0010, 3'd4);
    push(32'h1c00_0020, 3'd2);
    chk("t36_count", count_o, 3);
    chk("t36_valid", ifu_valid_o, 1);
    chk("t36_id", ifu_ftq_id_o, 0);
    chk("t36_pc", ifu_start_pc_o, 32'h1c00_0000);
    chk("t36_len", ifu_length_o, 4);

    // stream sends of ids 0,1,2
    ifu_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t38_valid", ifu_valid_o, 1);
      chk("t38_id", ifu_ftq_id_o, 64'(i));
      chk("t38_pc", ifu_start_pc_o, 64'(32'h1c00_0000 + 32'(i) * 32'h10));
      cyc();
    end
    ifu_ready_i = 1'b0;
    chk("t38_drained", ifu_valid_o, 0);
    commit(2'b11);
    chk("t38_count", count_o, 1);
    chk("t38_comm", dut.comm_ptr_q, 2);
    chk("t38_err", error_o, 0);

    // reset mid-operation clears immediately
    rst_n = 1'b0;
    #2;
    chk("t35_count", count_o, 0);
    chk("t35_valid", ifu_valid_o, 0);
    rst_n = 1'b1;
    cyc();

    // fill to full
    for (int i = 0; i < 8; i++) begin
      push(32'h2000_0000 + 32'(i) * 32'h10, 3'd1);
    end
    chk("t37_ready", bpu_ready_o, 0);
    chk("t37_count", count_o, 8);
    chk("t35_id0", ifu_ftq_id_o, 0);
    chk("t35_pc0", ifu_start_pc_o, 32'h2000_0000);
    push(32'hdead_beef, 3'd3);
    chk("t37_count9", count_o, 8);
    chk("t37_ready9", bpu_ready_o, 0);

    // flush with commit and dropped push
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h3000_0000 + 32'(i), 3'd2);
    send_n(3);
    backend_flush_i        = 1'b1;
    backend_flush_ftq_id_i = 3'd0;
    backend_commit_block_i = 2'b01;
    bpu_valid_i            = 1'b1;
    bpu_start_pc_i         = 32'h3333_3333;
    #1;
    chk("t39_valid_in_flush", ifu_valid_o, 0);
    cyc();
    backend_flush_i        = 1'b0;
    backend_commit_block_i = 2'b00;
    bpu_valid_i            = 1'b0;
    chk("t39_count", count_o, 0);
    chk("t39_valid", ifu_valid_o, 0);
    chk("t39_err", error_o, 0);
    push(32'h3000_0100, 3'd1);
    chk("t39_next_id", ifu_ftq_id_o, 1);
    chk("t39_next_pc", ifu_start_pc_o, 32'h3000_0100);
    chk("t39_next_count", count_o, 1);

    // wraparound from ptr 6
    do_reset();
    for (int i = 0; i < 6; i++) push(32'h4000_0000, 3'd1);
    send_n(6);
    commit(2'b11);
    commit(2'b11);
    commit(2'b11);
    chk("t40_base", dut.comm_ptr_q, 6);
    for (int i = 0; i < 4; i++) push(32'h5000_0000 + 32'(i), 3'd3);
    ifu_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t40_id", ifu_ftq_id_o, 64'((6 + i) % 8));
      chk("t40_pc", ifu_start_pc_o, 64'(32'h5000_0000 + 32'(i)));
      cyc();
    end
    ifu_ready_i = 1'b0;
    commit(2'b11);
    commit(2'b11);
    chk("t40_count", count_o, 0);
    chk("t40_comm", dut.comm_ptr_q, 2);
    chk("t40_err", error_o, 0);

    // over-commit is sticky
    do_reset();
    push(32'h6000_0000, 3'd1);
    send_n(1);
    commit(2'b11);
    chk("t41_comm", dut.comm_ptr_q, 1);
    chk("t41_err", error_o, 1);
    repeat (3) cyc();
    chk("t41_sticky", error_o, 1);
    rst_n = 1'b0;
    #2;
    chk("t41_rst", error_o, 0);
    rst_n = 1'b1;
    cyc();

    // wrong flush id
    push(32'h7000_0000, 3'd1);
    push(32'h7000_0010, 3'd1);
    send_n(1);
    backend_flush_i        = 1'b1;
    backend_flush_ftq_id_i = 3'd5;
    cyc();
    backend_flush_i = 1'b0;
    chk("badflush_err", error_o, 1);
    chk("badflush_count", count_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
